// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit: state enum, opcodes and ALU selects.
package control_unit_pkg;

    localparam int IR_W = 16;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOADA  = 4'd4,
        S_LOADB  = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/control_unit_ir_field_decoder.sv
// Purely combinational split of the instruction word into opcode and operand fields.
module ir_field_decoder
    import control_unit_pkg::*;
(
    input  logic [IR_W-1:0] i_ir,
    output logic [3:0]      o_opcode,
    output logic [7:0]      o_addr,
    output logic [3:0]      o_ra,
    output logic [3:0]      o_rb,
    output logic [3:0]      o_rd
);

    // LOAD/STORE reuse the low nibble as their register, so o_rd serves both formats.
    assign o_opcode = i_ir[15:12];
    assign o_addr   = i_ir[11:4];
    assign o_ra     = i_ir[11:8];
    assign o_rb     = i_ir[7:4];
    assign o_rd     = i_ir[3:0];

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetch, decode, then one or two execute states
// driving memory, register-file and ALU controls as Moore outputs.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int DADDR_W = 8,
    parameter int RF_AW   = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [15:0]        IR,
    output logic               PC_clr,
    output logic               PC_up,
    output logic               IR_ld,
    output logic [DADDR_W-1:0] D_addr,
    output logic               D_wr,
    output logic               RF_s,
    output logic [RF_AW-1:0]   RF_W_addr,
    output logic               RF_W_en,
    output logic [RF_AW-1:0]   RF_Ra_addr,
    output logic [RF_AW-1:0]   RF_Rb_addr,
    output logic [2:0]         ALU_s0,
    output logic [3:0]         OutState,
    output logic [3:0]         NextState
);

    logic [3:0] w_opcode;
    logic [7:0] w_addr;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rd;

    state_t r_state;
    state_t w_next;

    ir_field_decoder u_dec (
        .i_ir     (IR),
        .o_opcode (w_opcode),
        .o_addr   (w_addr),
        .o_ra     (w_ra),
        .o_rb     (w_rb),
        .o_rd     (w_rd)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= S_INIT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        PC_clr     = 1'b0;
        PC_up      = 1'b0;
        IR_ld      = 1'b0;
        D_addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;

        case (r_state)
            S_INIT: begin
                PC_clr = 1'b1;
                w_next = S_FETCH;
            end
            S_FETCH: begin
                IR_ld  = 1'b1;
                PC_up  = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_STORE: w_next = S_STORE;
                    OP_LOAD:  w_next = S_LOADA;
                    OP_ADD:   w_next = S_ADD;
                    OP_SUB:   w_next = S_SUB;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = S_NOOP;
                endcase
            end
            S_NOOP: begin
                w_next = S_FETCH;
            end
            // LoadA only presents the address; the synchronous memory returns data a cycle later.
            S_LOADA: begin
                D_addr = DADDR_W'(w_addr);
                RF_s   = 1'b1;
                w_next = S_LOADB;
            end
            S_LOADB: begin
                D_addr    = DADDR_W'(w_addr);
                RF_s      = 1'b1;
                RF_W_addr = RF_AW'(w_rd);
                RF_W_en   = 1'b1;
                w_next    = S_FETCH;
            end
            S_STORE: begin
                D_addr     = DADDR_W'(w_addr);
                RF_Ra_addr = RF_AW'(w_rd);
                D_wr       = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = RF_AW'(w_ra);
                RF_Rb_addr = RF_AW'(w_rb);
                RF_W_addr  = RF_AW'(w_rd);
                RF_W_en    = 1'b1;
                ALU_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_INIT;
            end
        endcase
    end

    assign OutState  = r_state;
    assign NextState = w_next;

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit with hand-computed expected outputs.
module tb_control_unit;

    logic        Clk;
    logic        Reset;
    logic [15:0] IR;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  OutState, NextState;
    logic [5:0]  ctl;

    int n_checks = 0;
    int n_errors = 0;

    control_unit #(.DADDR_W(8), .RF_AW(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IR         (IR),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState),
        .NextState  (NextState)
    );

    // {PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en}
    assign ctl = {PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic [3:0] nx, input logic [5:0] c);
        chk({tag, ".state"}, 32'(OutState), 32'(st));
        chk({tag, ".next"},  32'(NextState), 32'(nx));
        chk({tag, ".ctl"},   32'(ctl), 32'(c));
    endtask

    initial begin
        Reset = 1'b1;
        IR    = 16'h0000;
        cyc();
        cyc();
        chk_st("rst", 4'd0, 4'd1, 6'b100000);
        chk("rst.daddr", 32'(D_addr), 32'h0);
        chk("rst.alu",   32'(ALU_s0), 32'h0);

        Reset = 1'b0;
        IR    = 16'h3125;
        cyc(); chk_st("add.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("add.dec",   4'd2, 4'd7, 6'b000000);
        cyc(); chk_st("add.exec",  4'd7, 4'd1, 6'b000001);
        chk("add.ra",  32'(RF_Ra_addr), 32'd1);
        chk("add.rb",  32'(RF_Rb_addr), 32'd2);
        chk("add.wa",  32'(RF_W_addr),  32'd5);
        chk("add.alu", 32'(ALU_s0),     32'd1);

        IR = 16'h4125;
        cyc(); chk_st("sub.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("sub.dec",   4'd2, 4'd8, 6'b000000);
        cyc(); chk_st("sub.exec",  4'd8, 4'd1, 6'b000001);
        chk("sub.ra",  32'(RF_Ra_addr), 32'd1);
        chk("sub.rb",  32'(RF_Rb_addr), 32'd2);
        chk("sub.wa",  32'(RF_W_addr),  32'd5);
        chk("sub.alu", 32'(ALU_s0),     32'd2);

        IR = 16'h21B3;
        cyc(); chk_st("ld.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("ld.dec",   4'd2, 4'd4, 6'b000000);
        cyc(); chk_st("ld.a",     4'd4, 4'd5, 6'b000010);
        chk("ld.a.daddr", 32'(D_addr), 32'h1B);
        cyc(); chk_st("ld.b",     4'd5, 4'd1, 6'b000011);
        chk("ld.b.daddr", 32'(D_addr),    32'h1B);
        chk("ld.b.wa",    32'(RF_W_addr), 32'd3);

        IR = 16'h1807;
        cyc(); chk_st("st.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("st.dec",   4'd2, 4'd6, 6'b000000);
        cyc(); chk_st("st.exec",  4'd6, 4'd1, 6'b000100);
        chk("st.daddr", 32'(D_addr),     32'h80);
        chk("st.ra",    32'(RF_Ra_addr), 32'd7);

        IR = 16'hF000;
        cyc(); chk_st("nop.fetch", 4'd1, 4'd2, 6'b011000);
        chk("st.dwr_once", 32'(D_wr), 32'd0);
        cyc(); chk_st("nop.dec",   4'd2, 4'd3, 6'b000000);
        cyc(); chk_st("nop.exec",  4'd3, 4'd1, 6'b000000);

        // Rd = Ra on an ADD, then a reset pulse while in Add.
        IR = 16'h3121;
        cyc(); chk_st("add2.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("add2.dec",   4'd2, 4'd7, 6'b000000);
        cyc(); chk_st("add2.exec",  4'd7, 4'd1, 6'b000001);
        chk("add2.ra", 32'(RF_Ra_addr), 32'd1);
        chk("add2.wa", 32'(RF_W_addr),  32'd1);
        Reset = 1'b1;
        #1;
        chk_st("rst_add", 4'd0, 4'd1, 6'b100000);
        cyc(); chk_st("rst_add.hold", 4'd0, 4'd1, 6'b100000);
        Reset = 1'b0;
        IR    = 16'h5000;
        cyc(); chk_st("rel.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("halt.dec",  4'd2, 4'd9, 6'b000000);
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk_st("halt.hold", 4'd9, 4'd9, 6'b000000);
        end

        Reset = 1'b1;
        #1;
        chk_st("rst_halt", 4'd0, 4'd1, 6'b100000);
        cyc();
        Reset = 1'b0;
        IR    = 16'h21B3;
        cyc(); chk_st("ld2.fetch", 4'd1, 4'd2, 6'b011000);
        cyc(); chk_st("ld2.dec",   4'd2, 4'd4, 6'b000000);
        cyc(); chk_st("ld2.a",     4'd4, 4'd5, 6'b000010);
        Reset = 1'b1;
        #1;
        chk_st("rst_ld", 4'd0, 4'd1, 6'b100000);
        cyc(); chk_st("rst_ld.hold", 4'd0, 4'd1, 6'b100000);
        Reset = 1'b0;
        cyc(); chk_st("ld2.refetch", 4'd1, 4'd2, 6'b011000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
